// File: rtl/ibus_line_bridge.sv
// ibus_line_bridge
//   Instruction-fetch bridge between the core IBus and the CBus. Holds
//   NUM_LINES fully-associative line buffers of LINE_BEATS 64-bit beats.
//   Hits respond with zero wait; a miss issues a single CBus burst read that
//   refills a whole line, with round-robin replacement.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   flush                 invalidate all lines (fence.i), level-sampled
//   ireq_valid/addr       IBus request (held stable until data_ok)
//   iresp_addr_ok/data_ok/data   IBus response (32-bit instruction word)
//   icreq_*               CBus burst read request (size 8 bytes, len LINE_BEATS-1)
//   icresp_ready/last/data       CBus read beats
//   miss_count            misses since reset, wraps at 2^32
module ibus_line_bridge #(
  parameter int unsigned LINE_BEATS = 4,
  parameter int unsigned NUM_LINES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  output logic        icreq_valid,
  output logic        icreq_is_write,
  output logic [63:0] icreq_addr,
  output logic [2:0]  icreq_size,
  output logic [7:0]  icreq_len,
  output logic [7:0]  icreq_strobe,
  output logic [63:0] icreq_data,
  input  logic        icresp_ready,
  input  logic        icresp_last,
  input  logic [63:0] icresp_data,
  output logic [31:0] miss_count
);

  localparam int unsigned OFFW = $clog2(LINE_BEATS * 8);
  localparam int unsigned TAGW = 64 - OFFW;
  localparam int unsigned BW   = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int unsigned PW   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_FILL = 1'b1;

  logic                 state;
  logic [NUM_LINES-1:0] line_valid;
  logic [TAGW-1:0]      line_tag  [NUM_LINES];
  logic [63:0]          line_data [NUM_LINES][LINE_BEATS];
  logic [PW-1:0]        repl_ptr;
  logic [PW-1:0]        victim;
  logic [BW-1:0]        beat_cnt;
  logic                 flush_pending;
  logic [63:0]          fill_addr;

  logic [TAGW-1:0]      req_tag;
  logic [BW-1:0]        req_beat;
  logic                 hit;
  logic [PW-1:0]        hit_idx;
  logic [63:0]          hit_beat;
  logic                 serve;
  logic [BW-1:0]        beat_next;
  logic [PW-1:0]        ptr_next;

  assign req_tag = ireq_addr[63:OFFW];

  generate
    if (LINE_BEATS > 1) begin : g_beat_sel
      assign req_beat = ireq_addr[OFFW-1:3];
    end else begin : g_single_beat
      assign req_beat = '0;
    end
  endgenerate

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      if (!hit && line_valid[i] && (line_tag[i] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  assign hit_beat = line_data[hit_idx][req_beat];

  // Flush takes priority over a hit; the request is re-evaluated next cycle.
  assign serve         = (state == ST_IDLE) && ireq_valid && !flush && hit;
  assign iresp_addr_ok = serve;
  assign iresp_data_ok = serve;
  assign iresp_data    = serve ? (ireq_addr[2] ? hit_beat[63:32] : hit_beat[31:0]) : '0;

  // Request fields come straight from state so an asynchronous reset
  // drops the burst request in the same cycle.
  assign icreq_valid    = (state == ST_FILL);
  assign icreq_is_write = 1'b0;
  assign icreq_addr     = (state == ST_FILL) ? fill_addr : '0;
  assign icreq_size     = (state == ST_FILL) ? 3'b011 : 3'b000;
  assign icreq_len      = (state == ST_FILL) ? 8'(LINE_BEATS - 1) : 8'h00;
  assign icreq_strobe   = '0;
  assign icreq_data     = '0;

  assign beat_next = (beat_cnt == BW'(LINE_BEATS - 1)) ? '0 : beat_cnt + 1'b1;
  assign ptr_next  = (repl_ptr == PW'(NUM_LINES - 1)) ? '0 : repl_ptr + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      line_valid    <= '0;
      repl_ptr      <= '0;
      victim        <= '0;
      beat_cnt      <= '0;
      flush_pending <= 1'b0;
      fill_addr     <= '0;
      miss_count    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (flush) begin
            line_valid <= '0;
          end else if (ireq_valid && !hit) begin
            fill_addr              <= {req_tag, {OFFW{1'b0}}};
            victim                 <= repl_ptr;
            line_valid[repl_ptr]   <= 1'b0;
            miss_count             <= miss_count + 32'd1;
            beat_cnt               <= '0;
            flush_pending          <= 1'b0;
            state                  <= ST_FILL;
          end
        end
        default: begin
          // The burst cannot be aborted; a flush only marks the fill as stale.
          if (flush) begin
            line_valid    <= '0;
            flush_pending <= 1'b1;
          end
          if (icresp_ready) begin
            beat_cnt <= beat_next;
            if (icresp_last) begin
              if (!flush_pending && !flush) begin
                line_valid[victim] <= 1'b1;
              end
              repl_ptr      <= ptr_next;
              flush_pending <= 1'b0;
              state         <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  // Line storage carries no reset; validity alone decides whether it is used.
  always_ff @(posedge clk) begin
    if ((state == ST_FILL) && icresp_ready) begin
      line_data[victim][beat_cnt] <= icresp_data;
      if (icresp_last) begin
        line_tag[victim] <= fill_addr[63:OFFW];
      end
    end
  end

endmodule

// File: tb/tb_ibus_line_bridge.sv
module tb_ibus_line_bridge;
  localparam int unsigned LB = 4;
  localparam int unsigned NL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        icreq_valid;
  logic        icreq_is_write;
  logic [63:0] icreq_addr;
  logic [2:0]  icreq_size;
  logic [7:0]  icreq_len;
  logic [7:0]  icreq_strobe;
  logic [63:0] icreq_data;
  logic        icresp_ready;
  logic        icresp_last;
  logic [63:0] icresp_data;
  logic [31:0] miss_count;

  ibus_line_bridge #(.LINE_BEATS(LB), .NUM_LINES(NL)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .icreq_valid(icreq_valid), .icreq_is_write(icreq_is_write), .icreq_addr(icreq_addr),
    .icreq_size(icreq_size), .icreq_len(icreq_len), .icreq_strobe(icreq_strobe),
    .icreq_data(icreq_data),
    .icresp_ready(icresp_ready), .icresp_last(icresp_last), .icresp_data(icresp_data),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a set of cached line addresses plus an outstanding-fill record.
  bit          m_valid [NL];
  logic [63:0] m_line  [NL];
  int unsigned m_rr;
  bit          m_busy;
  logic [63:0] m_fill;
  int unsigned m_victim;
  bit          m_flushp;
  int unsigned m_misses;
  int unsigned m_beats;
  int unsigned rdy_mode;
  bit          tog;
  bit          last_hit;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[31:0];
    return (((lo >> 2) & 32'hF) * 32'h1111_1111) ^ (lo & 32'h7FFF_FFC0);
  endfunction

  function automatic logic [63:0] line_of(input logic [63:0] a);
    return a & ~64'(LB * 8 - 1);
  endfunction

  function automatic bit m_lookup(input logic [63:0] a);
    bit r;
    r = 1'b0;
    for (int i = 0; i < int'(NL); i++)
      if (m_valid[i] && m_line[i] == line_of(a)) r = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NL); i++) begin
      m_valid[i] = 1'b0;
      m_line[i]  = '0;
    end
    m_rr = 0; m_busy = 0; m_fill = '0; m_victim = 0;
    m_flushp = 0; m_misses = 0; m_beats = 0; last_hit = 0;
  endtask

  // One clock cycle: drive the CBus slave, check outputs, advance the model.
  task automatic tick();
    bit          rdy;
    bit          hit;
    logic [63:0] ba;
    if (m_busy) begin
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       begin rdy = tog; tog = !tog; end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ba           = m_fill + 64'(8 * m_beats);
      icresp_ready = rdy;
      icresp_data  = {mem_word(ba + 64'd4), mem_word(ba)};
      icresp_last  = (m_beats == LB - 1);
    end else begin
      rdy          = 1'b0;
      icresp_ready = 1'b0;
      icresp_data  = '0;
      icresp_last  = 1'b0;
    end
    #1;
    hit = !m_busy && ireq_valid && !flush && m_lookup(ireq_addr);
    chk("data_ok", 64'(iresp_data_ok), 64'(hit));
    chk("addr_ok", 64'(iresp_addr_ok), 64'(hit));
    chk("iresp_data", 64'(iresp_data), hit ? 64'(mem_word(ireq_addr)) : 64'd0);
    chk("icreq_valid", 64'(icreq_valid), 64'(m_busy));
    chk("icreq_addr", icreq_addr, m_busy ? m_fill : 64'd0);
    chk("icreq_len", 64'(icreq_len), m_busy ? 64'(LB - 1) : 64'd0);
    chk("icreq_size", 64'(icreq_size), m_busy ? 64'd3 : 64'd0);
    chk("icreq_wr", 64'({icreq_is_write, icreq_strobe}), 64'd0);
    chk("icreq_data", icreq_data, 64'd0);
    chk("miss_count", 64'(miss_count), 64'(m_misses));
    if (!m_busy) begin
      if (flush) begin
        for (int i = 0; i < int'(NL); i++) m_valid[i] = 1'b0;
      end else if (ireq_valid && !hit) begin
        m_busy = 1; m_fill = line_of(ireq_addr); m_victim = m_rr;
        m_valid[m_rr] = 1'b0; m_misses++; m_beats = 0; m_flushp = 0;
      end
    end else begin
      if (flush) begin
        for (int i = 0; i < int'(NL); i++) m_valid[i] = 1'b0;
      end
      if (rdy) begin
        if (m_beats == LB - 1) begin
          if (!m_flushp && !flush) begin
            m_valid[m_victim] = 1'b1;
            m_line[m_victim]  = m_fill;
          end
          m_rr   = (m_rr + 1) % NL;
          m_busy = 0;
        end
        m_beats++;
      end
      if (flush) m_flushp = 1;
    end
    last_hit = hit;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic access(input logic [63:0] a, output int cyc);
    ireq_valid = 1'b1;
    ireq_addr  = a;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!last_hit && cyc < 200);
    if (!last_hit) begin
      checks++;
      errors++;
      $error("FAIL access_timeout addr=%0h cycles=%0d required=data_ok", a, cyc);
    end
    ireq_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int          cyc;
    int unsigned m0;
    reset = 1'b1; flush = 1'b0; ireq_valid = 1'b0; ireq_addr = '0;
    icresp_ready = 1'b0; icresp_last = 1'b0; icresp_data = '0;
    rdy_mode = 0; tog = 1'b1;
    do_reset();

    // Reset state
    chk("rst_icreq_valid", 64'(icreq_valid), 64'd0);
    chk("rst_data_ok", 64'(iresp_data_ok), 64'd0);
    chk("rst_miss_count", 64'(miss_count), 64'd0);

    // First miss and sequential hits
    access(64'h8000_0000, cyc);
    chk("miss_latency", 64'(cyc), 64'd6);
    chk("miss_count_1", 64'(miss_count), 64'd1);
    for (int a = 4; a <= 'h1C; a += 4) begin
      access(64'h8000_0000 + 64'(a), cyc);
      chk("hit_latency", 64'(cyc), 64'd1);
    end
    chk("miss_count_after_hits", 64'(miss_count), 64'd1);

    // Flush and request together: flush wins, then a miss
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0008; flush = 1'b1;
    tick();
    flush = 1'b0;
    access(64'h8000_0008, cyc);
    chk("flush_then_miss", 64'(cyc), 64'd6);
    chk("miss_count_2", 64'(miss_count), 64'd2);

    // Round-robin eviction
    do_reset();
    access(64'h8000_0000, cyc);
    access(64'h8000_1000, cyc);
    access(64'h8000_2000, cyc);
    access(64'h8000_1004, cyc);
    chk("b_still_hits", 64'(cyc), 64'd1);
    access(64'h8000_0000, cyc);
    chk("a_evicted", 64'(cyc), 64'd6);
    chk("miss_count_4", 64'(miss_count), 64'd4);
    access(64'h8000_1000, cyc);
    chk("b_evicted", 64'(cyc), 64'd6);

    // Flush on the second beat of a fill
    m0 = m_misses;
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0040;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cyc = 0;
    while (m_busy && cyc < 50) begin tick(); cyc++; end
    access(64'h8000_0040, cyc);
    chk("refetch_after_flush", 64'(cyc), 64'd6);
    chk("miss_count_flush", 64'(miss_count), 64'(m0 + 2));
    access(64'h8000_1000, cyc);
    chk("old_line_flushed", 64'(cyc), 64'd6);

    // Ready toggling during the burst
    rdy_mode = 1; tog = 1'b1;
    access(64'h8000_0100, cyc);
    chk("toggle_latency", 64'(cyc), 64'd9);
    rdy_mode = 0;
    for (int a = 0; a < 32; a += 4) begin
      access(64'h8000_0100 + 64'(a), cyc);
      chk("toggle_hit", 64'(cyc), 64'd1);
    end

    // Reset in the middle of a fill
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0200;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_mid_icreq", 64'(icreq_valid), 64'd0);
    chk("rst_mid_resp", 64'({iresp_addr_ok, iresp_data_ok, iresp_data}), 64'd0);
    chk("rst_mid_misses", 64'(miss_count), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    access(64'h8000_0200, cyc);
    chk("after_reset_miss", 64'(cyc), 64'd6);
    chk("after_reset_count", 64'(miss_count), 64'd1);

    // Randomized traffic
    rdy_mode = 2;
    ireq_valid = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!ireq_valid || last_hit) begin
        ireq_valid = ($urandom_range(0, 3) != 0);
        ireq_addr  = 64'h8000_0000 + 64'($urandom_range(0, 2)) * 64'h1000
                   + 64'($urandom_range(0, 2)) * 64'h20 + 64'($urandom_range(0, 31));
      end
      flush = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush = 1'b0;
    ireq_valid = 1'b0;
    cyc = 0;
    while (m_busy && cyc < 100) begin tick(); cyc++; end
    chk("final_miss_count", 64'(miss_count), 64'(m_misses));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
